// File: rtl/seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seq_det_ctrl
// Purpose : Shifts WIDTH-bit words MSB first into a serial sequence detector
//           and counts its matches. Define SEQ_DET_CTRL_FLUSH_EN to reset the
//           detector in a LOAD cycle before every word.
// Rev     : 1.0  initial release
// ============================================================================
module seq_det_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DET_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             det_rst,
  output logic             det_inp,
  input  logic             det_outp,
  input  logic             clr_cnt,
  output logic             busy,
  output logic             word_done,
  output logic [3:0]       word_hits,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0]       c_SHIFT_LAST = 4'(WIDTH - 1);
  localparam logic [3:0]       c_DET_LAT    = 4'(DET_LAT);
  localparam logic [3:0]       c_DRAIN_LAST = 4'(DET_LAT - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [3:0]       r_bitcnt;
  logic [3:0]       r_hits;
  logic [3:0]       r_word_hits;
  logic [CNT_W-1:0] r_match_cnt;
  logic             w_hit;
  logic             w_to_done;

  // The first DET_LAT shift cycles still reflect the previous detector input.
  assign w_hit = det_outp &&
                 (((r_state == SHIFT) && (r_bitcnt >= c_DET_LAT)) || (r_state == DRAIN));

  assign w_to_done = ((r_state == SHIFT) && (r_bitcnt == c_SHIFT_LAST) && (DET_LAT == 0)) ||
                     ((r_state == DRAIN) && (r_bitcnt == c_DRAIN_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_hits      <= '0;
      r_word_hits <= '0;
      r_match_cnt <= '0;
    end else begin
      if (clr_cnt)
        r_match_cnt <= w_hit ? CNT_W'(1) : '0;
      else if (w_hit && (r_match_cnt != c_CNT_MAX))
        r_match_cnt <= r_match_cnt + CNT_W'(1);

      if (w_hit)
        r_hits <= r_hits + 4'd1;

      // Latch the final count together with the entry into DONE so it is
      // visible alongside the word_done pulse.
      if (w_to_done)
        r_word_hits <= r_hits + {3'b000, w_hit};

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift  <= in_data;
            r_hits   <= '0;
            r_bitcnt <= '0;
`ifdef SEQ_DET_CTRL_FLUSH_EN
            r_state  <= LOAD;
`else
            r_state  <= SHIFT;
`endif
          end
        end
        LOAD: r_state <= SHIFT;
        SHIFT: begin
          r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == c_SHIFT_LAST) begin
            r_bitcnt <= '0;
            r_state  <= (DET_LAT == 0) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == c_DRAIN_LAST)
            r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign word_done = (r_state == DONE);
  assign det_inp   = (r_state == SHIFT) && r_shift[WIDTH-1];
  assign word_hits = r_word_hits;
  assign match_cnt = r_match_cnt;

`ifdef SEQ_DET_CTRL_FLUSH_EN
  assign det_rst = rst || (r_state == LOAD);
`else
  assign det_rst = rst;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_det_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_det_ctrl
// Purpose : Self-checking bench for seq_det_ctrl (CNT_W=8 and CNT_W=2 copies).
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_det_ctrl;
  localparam int W = 8;
  localparam int L = 1;
`ifdef SEQ_DET_CTRL_FLUSH_EN
  localparam int FL      = 1;
  localparam int EXP_LAT = 10;
  localparam int EXP_DRST = 3;
`else
  localparam int FL      = 0;
  localparam int EXP_LAT = 9;
  localparam int EXP_DRST = 0;
`endif
  localparam int DONEP = FL + W + L + 1;

  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clr_cnt = 1'b0, det_outp = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready_a, det_rst_a, det_inp_a, busy_a, word_done_a;
  logic [3:0]   word_hits_a;
  logic [7:0]   match_cnt_a;
  logic         in_ready_b, det_rst_b, det_inp_b, busy_b, word_done_b;
  logic [3:0]   word_hits_b;
  logic [1:0]   match_cnt_b;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  seq_det_ctrl #(.WIDTH(W), .DET_LAT(L), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
    .det_rst(det_rst_a), .det_inp(det_inp_a), .det_outp(det_outp), .clr_cnt(clr_cnt),
    .busy(busy_a), .word_done(word_done_a), .word_hits(word_hits_a), .match_cnt(match_cnt_a));

  seq_det_ctrl #(.WIDTH(W), .DET_LAT(L), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .det_rst(det_rst_b), .det_inp(det_inp_b), .det_outp(det_outp), .clr_cnt(clr_cnt),
    .busy(busy_b), .word_done(word_done_b), .word_hits(word_hits_b), .match_cnt(match_cnt_b));

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Word model: phase p counts cycles since the accepting edge (p=1 first).
  bit           m_ok = 0, m_act = 0;
  int           m_p = 0, m_hits = 0, m_wh = 0, m_c8 = 0, m_c2 = 0;
  logic [W-1:0] m_data = '0;

  always @(posedge clk) begin
    int inc;
    if (rst) begin
      m_ok = 1; m_act = 0; m_p = 0; m_hits = 0; m_wh = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      inc = (m_act && m_p >= FL + 1 + L && m_p <= FL + W + L && det_outp) ? 1 : 0;
      if (clr_cnt) begin
        m_c8 = inc; m_c2 = inc;
      end else begin
        m_c8 = (m_c8 + inc > 255) ? 255 : m_c8 + inc;
        m_c2 = (m_c2 + inc > 3) ? 3 : m_c2 + inc;
      end
      if (m_act) begin
        m_hits = m_hits + inc;
        if (m_p == DONEP) m_act = 0;
        else begin
          m_p = m_p + 1;
          if (m_p == DONEP) m_wh = m_hits;
        end
      end else if (in_valid) begin
        m_act = 1; m_p = 1; m_data = in_data; m_hits = 0;
      end
    end
  end

  function automatic int exp_inp();
    if (m_act && m_p >= FL + 1 && m_p <= FL + W) return int'(m_data[W - FL - m_p]);
    return 0;
  endfunction

  function automatic int exp_drst();
    return (rst || (FL == 1 && m_act && m_p <= FL)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("in_ready_a", in_ready_a, m_act ? 0 : 1);
      chk("busy_a", busy_a, m_act ? 1 : 0);
      chk("word_done_a", word_done_a, (m_act && m_p == DONEP) ? 1 : 0);
      chk("det_inp_a", det_inp_a, exp_inp());
      chk("det_rst_a", det_rst_a, exp_drst());
      chk("word_hits_a", word_hits_a, m_wh);
      chk("match_cnt_a", match_cnt_a, m_c8);
      chk("in_ready_b", in_ready_b, m_act ? 0 : 1);
      chk("word_done_b", word_done_b, (m_act && m_p == DONEP) ? 1 : 0);
      chk("det_inp_b", det_inp_b, exp_inp());
      chk("det_rst_b", det_rst_b, exp_drst());
      chk("word_hits_b", word_hits_b, m_wh);
      chk("match_cnt_b", match_cnt_b, m_c2);
    end
  end

  // Called at #1 after an edge with the DUT idle; returns at #1 after the
  // edge that ends DONE.
  task automatic run_word(input logic [W-1:0] d, input logic [63:0] hmask,
                          input logic [63:0] cmask, output int lat, output logic [W-1:0] seq);
    bit seen = 0;
    lat = -1; seq = '0;
    in_valid = 1'b1; in_data = d;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      det_outp = hmask[k]; clr_cnt = cmask[k];
      @(negedge clk);
      if (k >= FL + 1 && k <= FL + W) seq[W - FL - k] = det_inp_a;
      if (word_done_a) begin seen = 1; lat = k - 1; end
      @(posedge clk); #1;
    end
    det_outp = 1'b0; clr_cnt = 1'b0;
    if (!seen) chk("word_done_timeout", 0, 1);
  endtask

  initial begin
    int lat, hs, dn, drst;
    logic prev_drst;
    logic [W-1:0] seq;
    logic [63:0] hm, cm;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk); chk("rst_det_rst", det_rst_a, 1);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_match_cnt", match_cnt_a, 0);
    @(posedge clk); #1;

    // 8'hB5 with three counted hits plus one in LOAD/first shift and one in DONE
    hm = '0; hm[1] = 1'b1; hm[3] = 1'b1; hm[6] = 1'b1; hm[9] = 1'b1; hm[DONEP] = 1'b1;
    run_word(8'hB5, hm, 64'd0, lat, seq);
    chk("b5_det_inp_seq", int'(seq), int'(8'b1011_0101));
    chk("b5_latency", lat, EXP_LAT);
    det_outp = 1'b1;
    @(negedge clk);
    chk("b5_word_hits", word_hits_a, 3);
    chk("b5_match_cnt", match_cnt_a, 3);
    @(posedge clk); #1; det_outp = 1'b0;
    @(negedge clk); chk("idle_hit_ignored", match_cnt_a, 3);
    @(posedge clk); #1;

    // Clear, then five matches: the 2-bit counter saturates
    clr_cnt = 1'b1;
    @(posedge clk); #1; clr_cnt = 1'b0;
    hm = '0; for (int k = 3; k <= 7; k++) hm[k] = 1'b1;
    run_word(8'h5A, hm, 64'd0, lat, seq);
    chk("sat_latency", lat, EXP_LAT);
    @(negedge clk);
    chk("sat_match_cnt_b", match_cnt_b, 3);
    chk("sat_match_cnt_a", match_cnt_a, 5);
    chk("sat_word_hits", word_hits_a, 5);
    @(posedge clk); #1;

    // Clear coincident with a match
    hm = '0; hm[4] = 1'b1; cm = '0; cm[4] = 1'b1;
    run_word(8'hC3, hm, cm, lat, seq);
    @(negedge clk);
    chk("clr_hit_match_cnt_a", match_cnt_a, 1);
    chk("clr_hit_match_cnt_b", match_cnt_b, 1);
    chk("clr_hit_word_hits", word_hits_a, 1);
    @(posedge clk); #1;

    // Reset in the fourth SHIFT cycle
    in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (FL + 3) begin @(posedge clk); #1; end
    rst = 1'b1; det_outp = 1'b1;
    @(negedge clk); chk("midword_det_rst", det_rst_a, 1);
    @(posedge clk); #1; rst = 1'b0; det_outp = 1'b0;
    @(negedge clk);
    chk("midword_in_ready", in_ready_a, 1);
    chk("midword_busy", busy_a, 0);
    chk("midword_match_cnt", match_cnt_a, 0);
    @(posedge clk); #1;
    hm = '0; hm[5] = 1'b1; hm[8] = 1'b1;
    run_word(8'h96, hm, 64'd0, lat, seq);
    chk("post_rst_latency", lat, EXP_LAT);
    chk("post_rst_det_inp_seq", int'(seq), int'(8'b1001_0110));
    @(negedge clk);
    chk("post_rst_word_hits", word_hits_a, 2);
    chk("post_rst_match_cnt", match_cnt_a, 2);
    @(posedge clk); #1;

    // Back-to-back words with in_valid held high
    hs = 0; dn = 0; drst = 0; prev_drst = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C;
    for (int c = 0; c < 100 && dn < 3; c++) begin
      det_outp = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready_a) hs++;
      if (word_done_a) dn++;
      if (det_rst_a && !prev_drst) drst++;
      prev_drst = det_rst_a;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; det_outp = 1'b0;
    chk("b2b_handshakes", hs, 3);
    chk("b2b_word_done", dn, 3);
    chk("b2b_det_rst_pulses", drst, EXP_DRST);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter WIDTH, 8, word length in bits shifted to the detector; legal range 2..15.
REQ-002 Parameter DET_LAT, 1, cycles from last bit presented until the detector output for that bit is valid; legal range 0..3.
REQ-003 Parameter CNT_W, 8, width of the running match counter.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  word offered by upstream.
REQ-007 in_data  input  WIDTH  word; bits are sent MSB first.
REQ-008 in_ready  output  1  controller can accept a word.
REQ-009 det_rst  output  1  reset to the serial sequence detector.
REQ-010 det_inp  output  1  serial bit to the detector.
REQ-011 det_outp  input  1  detector match flag.
REQ-012 clr_cnt  input  1  synchronous clear of match_cnt.
REQ-013 busy  output  1  word in flight (any state other than IDLE).
REQ-014 word_done  output  1  one-cycle pulse at the end of each word.
REQ-015 word_hits  output  4  matches counted in the last completed word; held until the next word_done.
REQ-016 match_cnt  output  CNT_W  running match total, saturating.

Function
REQ-017 The controller SHALL use states IDLE, LOAD, SHIFT, DRAIN and DONE.
REQ-018 In IDLE, in_ready SHALL be 1; all other states SHALL drive in_ready 0.
REQ-019 When in_valid and in_ready are both 1, the controller SHALL capture in_data into a shift register, clear its per-word hit counter, and leave IDLE.
REQ-020 LOAD SHALL last exactly 1 cycle, drive det_rst 1, and then go to SHIFT. LOAD exists only when the flush feature is enabled (REQ-032).
REQ-021 SHIFT SHALL last exactly WIDTH cycles, with det_inp equal to shift-register bit WIDTH-1 in each cycle; the register SHALL shift left by one each cycle.
REQ-022 Outside SHIFT, det_inp SHALL be 0.
REQ-023 DRAIN SHALL last DET_LAT cycles. When DET_LAT is 0, the controller SHALL skip DRAIN and go from SHIFT straight to DONE.
REQ-024 The per-word hit counter and match_cnt SHALL each increment by 1 in every cycle that det_outp is 1 and the state is SHIFT (excluding the first DET_LAT cycles of SHIFT) or DRAIN. det_outp SHALL be ignored in IDLE, LOAD and DONE.
REQ-025 DONE SHALL last 1 cycle: word_done is 1, word_hits is loaded from the per-word counter, and the next state is IDLE. The first new word can be accepted in the cycle after DONE.
REQ-026 Latency: from handshake to word_done SHALL be 1+WIDTH+DET_LAT cycles with flush enabled, and WIDTH+DET_LAT cycles without flush.
REQ-027 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 If clr_cnt and an increment occur in the same cycle, match_cnt SHALL become 1. A clr_cnt alone SHALL set match_cnt to 0. clr_cnt SHALL NOT affect the FSM or word_hits.
REQ-029 in_valid while busy SHALL be ignored; no word is lost, because in_ready is 0.

Reset
REQ-030 On rst=1 at a clock edge, from any state and including mid-word:
- state goes to IDLE
- shift register, per-word counter, word_hits and match_cnt are cleared to 0
- word_done and det_inp are 0
- in_ready is 1 and busy is 0 after the edge
REQ-031 det_rst SHALL equal 1 in every cycle that rst is 1, as well as during LOAD.

Configuration
REQ-032 Macro SEQ_DET_CTRL_FLUSH_EN:
- Defined: every word passes through LOAD, so the detector is reset before each word and patterns never span words.
- Undefined: IDLE goes directly to SHIFT, det_rst follows rst only, and detector state carries over so patterns can span word boundaries.

Verification
REQ-033 The bench SHALL drive det_outp from a scripted detector model and cover:
- Reset, then WIDTH=8, in_data=8'hB5 → det_inp sequence 1,0,1,1,0,1,0,1 over 8 consecutive cycles, then word_done after 9+DET_LAT cycles with flush, or 8+DET_LAT without.
- Model asserts det_outp on 3 cycles inside SHIFT/DRAIN of one word → word_hits=3 and match_cnt increases by 3. An assertion in DONE or IDLE is not counted.
- With CNT_W=2 and 5 matches → match_cnt stops at 3. Then clr_cnt coincident with a match → match_cnt=1.
- rst asserted in the 4th SHIFT cycle → next cycle in IDLE, in_ready=1, match_cnt=0, det_rst=1 during the reset cycle. A following word runs to completion normally.
- Back-to-back in_valid held high for 3 words → exactly 3 handshakes, 3 word_done pulses, in_ready=0 throughout each word.
- Flush on versus off: det_rst pulses once per word with SEQ_DET_CTRL_FLUSH_EN defined, and never after reset without it.
